reg32_arb: RTL and testbench
============================

REG32_ARB -- requirements
Module: reg32_arb

Interface
REQ-001 Parameter NREQ, default 4, sets the number of requesters; fixed at 4 in this revision.
REQ-002 Parameter MAXBURST, default 4, sets the maximum number of consecutive granted cycles per owner when another requester is waiting.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 R  input  1  reset, asynchronous, active-low.
REQ-005 req  input  4  per-requester access request; bit k belongs to requester k.
REQ-006 we  input  4  per-requester write enable; only honoured for the current owner.
REQ-007 wdata  input  128  write data, flattened; requester k drives bits [32k+31:32k].
REQ-008 gnt  output  4  one-hot or zero grant, registered.
REQ-009 owner  output  2  index of the current owner; holds the last owner when idle.
REQ-010 busy  output  1  high in state BUSY.
REQ-011 q  output  32  contents of the shared 32-bit register.

Function
REQ-012 The block SHALL implement a two-state FSM: IDLE (gnt=0) and BUSY (exactly one gnt bit high).
REQ-013 In IDLE, if req!=0 at an edge, the block SHALL enter BUSY and grant the first requester with req high, searching from ptr upward modulo 4.
REQ-014 Grant latency: req rising before edge e SHALL give gnt high in the cycle after e, with no combinational req->gnt path.
REQ-015 In BUSY, a write SHALL occur at an edge where gnt[owner]&req[owner]&we[owner]; q takes wdata slice [owner] at that edge.
REQ-016 we from non-owners, and we from the owner while its req is low, SHALL be ignored.
REQ-017 burst counter cnt SHALL start at 0 on each new grant and increment at every BUSY edge where the owner keeps grant.
REQ-018 Release SHALL occur at an edge where req[owner]=0, or where cnt=MAXBURST-1 and some other req bit is high.
REQ-019 On release, ptr SHALL become owner+1 mod 4, wrapping from 3 to 0.
REQ-020 On release with other requests pending, the next owner SHALL be granted at the same edge (no idle bubble), chosen per REQ-013 with the new ptr; otherwise the FSM SHALL return to IDLE.
REQ-021 When cnt reaches MAXBURST-1 and no other request is pending, the owner SHALL retain grant and cnt SHALL wrap to 0.
REQ-022 A requester SHALL NOT be re-granted while any other requester with req high was skipped since its last grant, giving round-robin fairness with a bound of 3*MAXBURST waiting cycles.
REQ-023 q SHALL change only on writes per REQ-015 and SHALL otherwise hold its value.

Reset
REQ-024 While R=0, asynchronously: state=IDLE, gnt=0, busy=0, owner=0, ptr=0, cnt=0, q=32'h0.
REQ-025 Reset asserted mid-burst SHALL abort the grant immediately; the write at that edge SHALL be lost.
REQ-026 After R rises, the first grant SHALL follow REQ-013 with ptr=0.

Structure
REQ-027 A shared package SHALL hold NREQ, MAXBURST defaults, the FSM state encoding (IDLE=0, BUSY=1) and the 32-bit data width constant.
REQ-028 The storage SHALL be a single sub-module reg32_ce: a 32-bit register with load enable and asynchronous active-low reset, instantiated once.
REQ-029 Arbitration, FSM, ptr and cnt SHALL reside in reg32_arb.

Verification
REQ-030 Reset then req=4'b0010, we=4'b0010, wdata[63:32]=32'hDEADBEEF -> gnt=4'b0010 after 1 edge, q=32'hDEADBEEF after 2 edges, owner=1.
REQ-031 req=4'b1111 held, we=0 -> gnt sequence 0001 x4, 0010 x4, 0100 x4, 1000 x4, 0001, with no gap cycles.
REQ-032 Only req[2] held for 10 cycles -> gnt=4'b0100 continuously, busy=1 throughout, cnt wraps.
REQ-033 Owner 3 drops req while req[0]=1 -> next edge gnt=4'b0001 (ptr wraps 3->0), with no IDLE cycle.
REQ-034 R pulsed low mid-burst with we[owner]=1, wdata=32'h12345678 -> gnt=0 and q=0 immediately, and q never equals 32'h12345678.
REQ-035 Non-owner we[1]=1 with wdata=32'hFFFFFFFF while owner 0 has we=0 -> q unchanged.

Source files
------------

// File: rtl/reg32_arb_pkg.sv
// Shared constants, FSM encoding and the round-robin search helper for the
// reg32_arb shared-register arbiter.
package reg32_arb_pkg;

  localparam int NREQ_DEF     = 4;
  localparam int MAXBURST_DEF = 4;
  localparam int DW           = 32;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // First requester with its bit set, searching from ptr upward modulo 4.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [1:0] idx;
    logic       found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/reg32_arb_if.sv
// Requester-side bus of the shared register: requests, write ports, grant
// status and the register contents.
interface reg32_arb_if;
  import reg32_arb_pkg::*;

  logic [3:0]      req;
  logic [3:0]      we;
  logic [4*DW-1:0] wdata;
  logic [3:0]      gnt;
  logic [1:0]      owner;
  logic            busy;
  logic [DW-1:0]   q;

  modport master (output req, we, wdata, input gnt, owner, busy, q);
  modport slave  (input req, we, wdata, output gnt, owner, busy, q);
endinterface

// File: rtl/reg32_ce.sv
// 32-bit storage register with load enable and asynchronous active-low reset.
module reg32_ce
  import reg32_arb_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ce,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= '0;
    else if (ce) q <= d;
  end

endmodule

// File: rtl/reg32_arb.sv
// Round-robin arbiter granting one of four requesters write access to a
// shared 32-bit register, with a burst limit while others are waiting.
module reg32_arb
  import reg32_arb_pkg::*;
#(
  parameter int NREQ     = NREQ_DEF,
  parameter int MAXBURST = MAXBURST_DEF
) (
  input  logic        clk,
  input  logic        R,
  reg32_arb_if.slave  bus
);

  localparam int CW = (MAXBURST > 1) ? $clog2(MAXBURST) : 1;

  state_t          state;
  logic [NREQ-1:0] gnt;
  logic [1:0]      owner;
  logic [1:0]      ptr;
  logic [CW-1:0]   cnt;

  logic [3:0]      others;
  logic            burst_end;
  logic            release_now;
  logic [1:0]      nxt_ptr;
  logic [1:0]      idle_pick;
  logic [1:0]      busy_pick;
  logic            wr_en;
  logic [DW-1:0]   wr_data;

  // NOTE: every always_comb output gets a value on every path, so no latch
  // can be inferred.
  always_comb begin
    others      = bus.req & ~gnt;
    burst_end   = (cnt == CW'(MAXBURST - 1));
    release_now = (state == BUSY) && (!bus.req[owner] || (burst_end && (|others)));
    nxt_ptr     = owner + 2'd1;
    idle_pick   = rr_pick(bus.req, ptr);
    busy_pick   = rr_pick(others, nxt_ptr);
    wr_en       = (state == BUSY) && bus.req[owner] && bus.we[owner];
    wr_data     = bus.wdata[DW*int'(owner) +: DW];
  end

  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      state <= IDLE;
      gnt   <= '0;
      owner <= '0;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|bus.req) begin
            state <= BUSY;
            owner <= idle_pick;
            gnt   <= NREQ'(1) << idle_pick;
            cnt   <= '0;
          end
        end
        BUSY: begin
          if (release_now) begin
            ptr <= nxt_ptr;
            // Hand over at the same edge when someone else is waiting.
            if (|others) begin
              owner <= busy_pick;
              gnt   <= NREQ'(1) << busy_pick;
              cnt   <= '0;
            end else begin
              state <= IDLE;
              gnt   <= '0;
            end
          end else begin
            cnt <= burst_end ? '0 : cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  reg32_ce u_reg (
    .clk   (clk),
    .rst_n (R),
    .ce    (wr_en),
    .d     (wr_data),
    .q     (bus.q)
  );

  assign bus.gnt   = gnt;
  assign bus.owner = owner;
  assign bus.busy  = (state == BUSY);

endmodule

// File: tb/tb_reg32_arb.sv
// Directed self-checking bench for reg32_arb: grant latency, round-robin
// rotation, burst wrap, pointer wrap, mid-burst reset and write filtering.
module tb_reg32_arb;

  logic clk = 1'b0;
  logic R   = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic hit_forbidden = 1'b0;

  reg32_arb_if bus ();

  reg32_arb dut (
    .clk (clk),
    .R   (R),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(bus.q) if (bus.q === 32'h12345678) hit_forbidden = 1'b1;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    R = 1'b0;
    bus.req = '0; bus.we = '0; bus.wdata = '0;
    step();
    R = 1'b1;
  endtask

  task automatic test_reset();
    bus.req = '0; bus.we = '0; bus.wdata = '0;
    R = 1'b0;
    step();
    n_cmp++; if (bus.gnt !== 4'b0000) begin n_bad++; $display("FAIL rst_gnt: got %b want 0000", bus.gnt); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.owner !== 2'd0) begin n_bad++; $display("FAIL rst_owner: got %0d want 0", bus.owner); end
    n_cmp++; if (bus.q !== 32'h0) begin n_bad++; $display("FAIL rst_q: got %h want 0", bus.q); end
    R = 1'b1;
  endtask

  task automatic test_single_write();
    bus.req = 4'b0010; bus.we = 4'b0010; bus.wdata[63:32] = 32'hDEADBEEF;
    step();
    n_cmp++; if (bus.gnt !== 4'b0010) begin n_bad++; $display("FAIL wr_gnt: got %b want 0010", bus.gnt); end
    n_cmp++; if (bus.owner !== 2'd1) begin n_bad++; $display("FAIL wr_owner: got %0d want 1", bus.owner); end
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL wr_busy: got %b want 1", bus.busy); end
    n_cmp++; if (bus.q !== 32'h0) begin n_bad++; $display("FAIL wr_q_early: got %h want 0", bus.q); end
    step();
    n_cmp++; if (bus.q !== 32'hDEADBEEF) begin n_bad++; $display("FAIL wr_q: got %h want deadbeef", bus.q); end
    bus.req = '0; bus.we = '0;
    step();
    n_cmp++; if (bus.gnt !== 4'b0000) begin n_bad++; $display("FAIL wr_idle_gnt: got %b want 0000", bus.gnt); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL wr_idle_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.owner !== 2'd1) begin n_bad++; $display("FAIL wr_hold_owner: got %0d want 1", bus.owner); end
    n_cmp++; if (bus.q !== 32'hDEADBEEF) begin n_bad++; $display("FAIL wr_hold_q: got %h want deadbeef", bus.q); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp;
    do_reset();
    bus.req = 4'b1111; bus.we = '0;
    for (int k = 0; k < 17; k++) begin
      step();
      exp = 4'b0001 << ((k / 4) % 4);
      n_cmp++; if (bus.gnt !== exp) begin n_bad++; $display("FAIL rr_gnt[%0d]: got %b want %b", k, bus.gnt, exp); end
      n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL rr_busy[%0d]: got %b want 1", k, bus.busy); end
    end
    n_cmp++; if (bus.q !== 32'h0) begin n_bad++; $display("FAIL rr_q: got %h want 0", bus.q); end
    bus.req = '0;
    step();
    n_cmp++; if (bus.gnt !== 4'b0000) begin n_bad++; $display("FAIL rr_idle: got %b want 0000", bus.gnt); end
  endtask

  // ptr is 1 here; requester 2 alone keeps the grant through cnt wraps.
  task automatic test_single_owner();
    bus.req = 4'b0100; bus.we = '0;
    for (int k = 0; k < 10; k++) begin
      step();
      n_cmp++; if (bus.gnt !== 4'b0100 || bus.busy !== 1'b1) begin
        n_bad++; $display("FAIL solo[%0d]: got gnt=%b busy=%b want gnt=0100 busy=1", k, bus.gnt, bus.busy);
      end
    end
    // cnt is 1 after ten grant edges: two more edges hold, the third hands over.
    bus.req = 4'b0101;
    step();
    n_cmp++; if (bus.gnt !== 4'b0100) begin n_bad++; $display("FAIL wrap_hold1: got %b want 0100", bus.gnt); end
    step();
    n_cmp++; if (bus.gnt !== 4'b0100) begin n_bad++; $display("FAIL wrap_hold2: got %b want 0100", bus.gnt); end
    step();
    n_cmp++; if (bus.gnt !== 4'b0001) begin n_bad++; $display("FAIL wrap_switch: got %b want 0001", bus.gnt); end
  endtask

  task automatic test_owner3_drop();
    bus.req = 4'b1000;
    step();
    n_cmp++; if (bus.gnt !== 4'b1000 || bus.owner !== 2'd3) begin
      n_bad++; $display("FAIL own3: got gnt=%b owner=%0d want gnt=1000 owner=3", bus.gnt, bus.owner);
    end
    bus.req = 4'b0001;
    step();
    n_cmp++; if (bus.gnt !== 4'b0001) begin n_bad++; $display("FAIL drop_gnt: got %b want 0001", bus.gnt); end
    n_cmp++; if (bus.owner !== 2'd0) begin n_bad++; $display("FAIL drop_owner: got %0d want 0", bus.owner); end
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL drop_busy: got %b want 1", bus.busy); end
    bus.req = '0;
    step();
  endtask

  task automatic test_reset_midburst();
    bus.req = 4'b0001; bus.we = 4'b0001; bus.wdata[31:0] = 32'hA5A5A5A5;
    step();
    step();
    n_cmp++; if (bus.q !== 32'hA5A5A5A5) begin n_bad++; $display("FAIL mb_pre_q: got %h want a5a5a5a5", bus.q); end
    bus.wdata[31:0] = 32'h12345678;
    #2 R = 1'b0;
    #1;
    n_cmp++; if (bus.gnt !== 4'b0000) begin n_bad++; $display("FAIL mb_gnt: got %b want 0000", bus.gnt); end
    n_cmp++; if (bus.q !== 32'h0) begin n_bad++; $display("FAIL mb_q: got %h want 0", bus.q); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL mb_busy: got %b want 0", bus.busy); end
    step();
    R = 1'b1; bus.req = '0; bus.we = '0;
    step();
    n_cmp++; if (bus.q !== 32'h0 || bus.gnt !== 4'b0000) begin
      n_bad++; $display("FAIL mb_after: got q=%h gnt=%b want q=0 gnt=0000", bus.q, bus.gnt);
    end
    n_cmp++; if (hit_forbidden !== 1'b0) begin n_bad++; $display("FAIL mb_lost_write: got q=12345678 seen want never"); end
  endtask

  task automatic test_nonowner_we();
    bus.req = 4'b0001; bus.we = 4'b0001; bus.wdata[31:0] = 32'hCAFEF00D;
    step();
    step();
    n_cmp++; if (bus.q !== 32'hCAFEF00D) begin n_bad++; $display("FAIL no_pre_q: got %h want cafef00d", bus.q); end
    bus.req = 4'b0011; bus.we = 4'b0010; bus.wdata[63:32] = 32'hFFFFFFFF;
    step();
    step();
    n_cmp++; if (bus.q !== 32'hCAFEF00D) begin n_bad++; $display("FAIL no_q: got %h want cafef00d", bus.q); end
    n_cmp++; if (bus.gnt !== 4'b0001) begin n_bad++; $display("FAIL no_gnt: got %b want 0001", bus.gnt); end
    bus.req = '0; bus.we = '0;
    step();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_single_owner();
    test_owner3_drop();
    test_reset_midburst();
    test_nonowner_we();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
